// File: rtl/ipsxe_floating_point_log_16_obuf_v1_0.sv
// Credit-gated result buffer for the half-precision ln core: FWFT FIFO with upstream credit flow.
// Define IPSXE_LOG16_OBUF_STATUS_EN to generate the o_fifo_count / o_ovf_err status outputs.
module ipsxe_floating_point_log_16_obuf_v1_0 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_s_tvalid,
    output logic                          o_s_tready,
    output logic                          o_core_valid,
    input  logic [DATA_WIDTH-1:0]         i_res_data,
    input  logic [2:0]                    i_res_flags,
    input  logic                          i_res_valid,
    output logic [DATA_WIDTH-1:0]         o_m_tdata,
    output logic [2:0]                    o_m_tuser,
    output logic                          o_m_tvalid,
    input  logic                          i_m_tready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_ovf_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + 3;
    localparam logic [AW:0] PtrOne     = PW'(1);
    localparam logic [AW:0] CreditInit = PW'(FIFO_DEPTH);

    logic [AW:0]   credit_q, credit_d;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [EW-1:0] mem [FIFO_DEPTH];

    logic empty, full, up_hs, dn_hs, wr_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Credits count entries not yet claimed by an in-flight or stored result.
    assign o_s_tready   = (credit_q != '0);
    assign o_core_valid = i_s_tvalid & o_s_tready;

    assign o_m_tvalid = !empty;
    assign up_hs      = o_core_valid;
    assign dn_hs      = o_m_tvalid & i_m_tready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en      = i_res_valid & (!full | dn_hs);

    always_comb begin
        credit_d = credit_q;
        if (up_hs && !dn_hs) begin
            credit_d = credit_q - PtrOne;
        end else if (dn_hs && !up_hs) begin
            credit_d = credit_q + PtrOne;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            credit_q <= CreditInit;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            credit_q <= credit_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (dn_hs) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {i_res_flags, i_res_data};
        end
    end

    assign {o_m_tuser, o_m_tdata} = mem[rd_ptr_q[AW-1:0]];

`ifdef IPSXE_LOG16_OBUF_STATUS_EN
    logic ovf_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (i_res_valid && !wr_en) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_fifo_count = wr_ptr_q - rd_ptr_q;
    assign o_ovf_err    = ovf_q;
`else
    assign o_fifo_count = '0;
    assign o_ovf_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_log_16_obuf_v1_0.sv
// Bench for the ln result buffer: queue-based model, per-cycle compare, emulated 13-stage core.
module tb_ipsxe_floating_point_log_16_obuf_v1_0;

    localparam int unsigned DEPTH = 16;
`ifdef IPSXE_LOG16_OBUF_STATUS_EN
    localparam bit StatusEn = 1'b1;
`else
    localparam bit StatusEn = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_s_tvalid = 1'b1;
    logic        i_res_valid = 1'b0;
    logic        i_m_tready = 1'b0;
    logic [15:0] i_res_data = '0;
    logic [2:0]  i_res_flags = '0;
    logic        o_s_tready, o_core_valid, o_m_tvalid, o_ovf_err;
    logic [15:0] o_m_tdata;
    logic [2:0]  o_m_tuser;
    logic [4:0]  o_fifo_count;

    ipsxe_floating_point_log_16_obuf_v1_0 #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_s_tvalid   (i_s_tvalid),
        .o_s_tready   (o_s_tready),
        .o_core_valid (o_core_valid),
        .i_res_data   (i_res_data),
        .i_res_flags  (i_res_flags),
        .i_res_valid  (i_res_valid),
        .o_m_tdata    (o_m_tdata),
        .o_m_tuser    (o_m_tuser),
        .o_m_tvalid   (o_m_tvalid),
        .i_m_tready   (i_m_tready),
        .o_fifo_count (o_fifo_count),
        .o_ovf_err    (o_ovf_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents as a queue, credits as a plain integer.
    logic [18:0] mq[$];
    int          m_cred = DEPTH;
    bit          m_ovf = 1'b0;

    initial begin
        bit up, dn, wr;
        forever begin
            @(posedge i_clk or posedge i_rst);
            if (i_rst) begin
                mq.delete();
                m_cred = DEPTH;
                m_ovf  = 1'b0;
            end else begin
                up = i_s_tvalid && (m_cred != 0);
                dn = i_m_tready && (mq.size() != 0);
                wr = i_res_valid && ((mq.size() < DEPTH) || dn);
                if (dn) void'(mq.pop_front());
                if (wr) mq.push_back({i_res_flags, i_res_data});
                else if (i_res_valid) m_ovf = 1'b1;
                m_cred = m_cred - int'(up) + int'(dn);
            end
        end
    end

    // Compare process: every negedge, all outputs against the model.
    initial begin
        logic [18:0] prev = '0;
        bit          prev_stall = 1'b0;
        forever begin
            @(negedge i_clk);
            chk("s_tready", o_s_tready, m_cred != 0);
            chk("core_valid", o_core_valid, i_s_tvalid && (m_cred != 0));
            chk("m_tvalid", o_m_tvalid, mq.size() != 0);
            if (mq.size() != 0) chk("m_data", {o_m_tuser, o_m_tdata}, mq[0]);
            chk("fifo_count", o_fifo_count, StatusEn ? mq.size() : 0);
            chk("ovf_err", o_ovf_err, StatusEn ? m_ovf : 1'b0);
            if (prev_stall && mq.size() != 0) chk("stall_hold", {o_m_tuser, o_m_tdata}, prev);
            prev_stall = (mq.size() != 0) && !i_m_tready && !i_rst;
            prev = {o_m_tuser, o_m_tdata};
        end
    end

    // Emulated log core: fixed-latency valid pipeline fed by o_core_valid.
    bit pipe[13];
    bit inject = 1'b0;
    bit fixed_en = 1'b0;
    bit last_tready;
    int up_cnt = 0;
    int dn_cnt = 0;

    task automatic cyc();
        bit cv;
        @(negedge i_clk);
        cv = o_core_valid && !i_rst;
        last_tready = o_s_tready;
        if (o_m_tvalid && i_m_tready) dn_cnt++;
        if (cv) up_cnt++;
        @(posedge i_clk);
        #1;
        for (int i = 12; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = cv;
        i_res_valid = pipe[12] | inject;
        if (fixed_en) begin
            i_res_data  = 16'h3C00;
            i_res_flags = 3'b000;
        end else begin
            i_res_data  = 16'($urandom);
            i_res_flags = 3'($urandom);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 13; i++) pipe[i] = 1'b0;
        i_res_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clear_pipe();
        repeat (3) cyc();
        i_rst = 1'b0;
    endtask

    initial begin
        bit seen;
        clear_pipe();

        // Reset held 3 cycles with upstream valid.
        repeat (3) cyc();
        chk("rst_s_tready", o_s_tready, 1);
        chk("rst_core_valid", o_core_valid, 1);
        chk("rst_m_tvalid", o_m_tvalid, 0);
        chk("rst_fifo_count", o_fifo_count, 0);
        chk("rst_ovf_err", o_ovf_err, 0);
        i_rst = 1'b0;
        i_s_tvalid = 1'b0;
        cyc();

        // Single result 16'h3C00 through the core path.
        fixed_en = 1'b1;
        i_s_tvalid = 1'b1;
        cyc();
        i_s_tvalid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            cyc();
            seen = o_m_tvalid;
        end
        chk("single_arrived", seen, 1);
        chk("single_data", o_m_tdata, 16'h3C00);
        chk("single_flags", o_m_tuser, 3'b000);
        i_m_tready = 1'b1;
        cyc();
        i_m_tready = 1'b0;
        fixed_en = 1'b0;
        chk("single_drained", o_m_tvalid, 0);

        // Backpressure fill: 20 cycles of upstream valid, downstream stalled.
        up_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            i_s_tvalid = 1'b1;
            cyc();
            chk("fill_tready", last_tready, (i < 16) ? 1 : 0);
        end
        chk("fill_handshakes", up_cnt, 16);
        i_s_tvalid = 1'b0;
        repeat (20) cyc();
        chk("fill_count", o_fifo_count, StatusEn ? 16 : 0);
        chk("fill_ovf", o_ovf_err, 0);
        chk("fill_tvalid", o_m_tvalid, 1);

        // Fault injection on a full FIFO: with and without a same-cycle read.
        inject = 1'b1;
        cyc();
        i_m_tready = 1'b1;
        inject = 1'b0;
        cyc();
        i_m_tready = 1'b0;
        chk("full_rw_count", o_fifo_count, StatusEn ? 16 : 0);
        chk("full_rw_ovf", o_ovf_err, 0);
        inject = 1'b1;
        cyc();
        inject = 1'b0;
        cyc();
        chk("full_drop_ovf", o_ovf_err, StatusEn ? 1 : 0);
        chk("full_drop_count", o_fifo_count, StatusEn ? 16 : 0);
        do_reset();
        chk("post_fault_ovf", o_ovf_err, 0);

        // Random ordering run: 40 results, random upstream valid and downstream ready.
        up_cnt = 0;
        dn_cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            i_s_tvalid = (up_cnt < 40) && ($urandom_range(0, 3) != 0);
            i_m_tready = 1'($urandom_range(0, 1));
            cyc();
            seen = (up_cnt == 40) && (dn_cnt == 40);
        end
        chk("rand_done", seen, 1);
        chk("rand_in", up_cnt, 40);
        chk("rand_out", dn_cnt, 40);
        i_s_tvalid = 1'b0;
        i_m_tready = 1'b0;

        // Reset mid-stream with 7 stored entries.
        up_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            i_s_tvalid = (up_cnt < 7);
            cyc();
        end
        i_s_tvalid = 1'b0;
        chk("mid_count", o_fifo_count, StatusEn ? 7 : 0);
        chk("mid_tvalid", o_m_tvalid, 1);
        i_rst = 1'b1;
        clear_pipe();
        #1;
        chk("mid_rst_tvalid", o_m_tvalid, 0);
        chk("mid_rst_tready", o_s_tready, 1);
        chk("mid_rst_count", o_fifo_count, 0);
        repeat (2) cyc();
        i_rst = 1'b0;

        // One more result after reset to confirm normal operation.
        i_s_tvalid = 1'b1;
        i_m_tready = 1'b1;
        cyc();
        i_s_tvalid = 1'b0;
        repeat (20) cyc();
        chk("post_rst_empty", o_m_tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
